mem8_arbiter: RTL and testbench
===============================

Name: mem8_arbiter

Overview:
Shares the 32 x 8 inferred RAM behind /dev/xillybus_mem_8 between two requesters: the host, through the Xillybus mem_8 stream ports, and a local fabric requester, through a req/gnt port. Arbitration is round-robin with a burst limit per tenure. The host is stalled by holding user_r_mem_8_empty and user_w_mem_8_full high while it does not own the RAM. The block sits between xillybus_ins and the RAM in the bus_clk domain.

Parameters:
ADDR_W, 5, RAM address width (depth 2**ADDR_W)
DATA_W, 8, RAM data width
MAX_BURST, 16, maximum accesses per tenure before a waiting requester takes over (range 1..255)

Ports:
bus_clk  in  1  clock; all logic is on its rising edge
srst  in  1  synchronous active-high reset
user_r_mem_8_rden  in  1  host read strobe
user_r_mem_8_empty  out  1  host read stall
user_r_mem_8_data  out  DATA_W  host read data
user_r_mem_8_open  in  1  host read file open
user_w_mem_8_wren  in  1  host write strobe
user_w_mem_8_full  out  1  host write stall
user_w_mem_8_data  in  DATA_W  host write data
user_w_mem_8_open  in  1  host write file open
user_mem_8_addr  in  ADDR_W  host address
loc_req  in  1  local request, held high for the whole tenure
loc_we  in  1  local access is a write (1) or a read (0)
loc_addr  in  ADDR_W  local address
loc_wdata  in  DATA_W  local write data
loc_gnt  out  1  local access accepted this cycle
loc_rvalid  out  1  local read data valid
loc_rdata  out  DATA_W  local read data
ram_rden  out  1  RAM read enable
ram_wren  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM registered read data, 1-cycle latency, read-before-write

Behaviour:
- Reset (srst=1 at the clock edge):
  - state=IDLE, burst count=0, last owner=LOCAL (so the host wins the first tie).
  - user_r_mem_8_empty=1, user_w_mem_8_full=1, loc_gnt=0, loc_rvalid=0, ram_rden=0, ram_wren=0.
- Requests:
  - host_req = user_r_mem_8_open | user_w_mem_8_open.
  - local request = loc_req.
- States IDLE / HOST / LOCAL; the state is registered.
  - empty and full are 0 only while state==HOST; both are 1 otherwise, including in the reset cycle.
- IDLE:
  - If only one requester is active, go to it.
  - If both are active, go to the one that is not last owner.
  - If neither is active, stay.
- HOST:
  - RAM signals are driven combinationally: ram_rden=rden, ram_wren=wren, ram_addr=user_mem_8_addr, ram_wdata=user_w_mem_8_data.
  - rden and wren in the same cycle are both honoured.
  - An access is a cycle with rden|wren. The count increments once per access cycle.
- LOCAL:
  - loc_gnt = loc_req, combinationally.
  - ram_rden = loc_req & ~loc_we, ram_wren = loc_req & loc_we, ram_addr=loc_addr, ram_wdata=loc_wdata.
  - Each gnt cycle is one access and increments the count.
- Switching:
  - Leave HOST when host_req drops, or when the access that brings the count to MAX_BURST completes while loc_req=1.
  - Leave LOCAL when loc_req drops, or at MAX_BURST while host_req=1.
  - If the other side is requesting, go directly to it; otherwise go to IDLE.
  - If the count reaches MAX_BURST and the other side is not requesting, the count resets to 0 and the current owner keeps the RAM.
  - Entering any state clears the count and updates last owner.
- Accesses in the final cycle of a tenure always complete; the stall takes effect on the next cycle. There is no dead cycle between owners.
- Read data:
  - user_r_mem_8_data = ram_rdata, valid the cycle after rden, matching the Xillybus timing.
  - loc_rdata = ram_rdata.
  - loc_rvalid is registered: 1 exactly one cycle after a local read grant.
- Reset mid-tenure drops ownership immediately. A pending loc_rvalid is cleared. RAM contents are untouched.
- A host open that drops in the same cycle as an access: the access completes, then the next state is chosen.
- Address wrap-around is handled by the Xillybus core; this block passes the address through unmodified.

Optional Feature:
MEM8_ARB_HOST_PRIO_EN
- Defined:
  - Fixed host priority: the host wins ties in IDLE.
  - LOCAL is preempted as soon as host_req=1, after the current gnt cycle.
  - The host burst limit is ignored.
- Undefined: round-robin with MAX_BURST as described above.

Test Plan:
1. Reset, then write_open=1 only, host writes 0xA5 to addr 3 -> full=0 from the second cycle after reset; ram_wren=1 with addr 3 and data 0xA5.
2. Local only: loc_req=1, loc_we=0, loc_addr=3 -> loc_gnt=1 in the cycle after the LOCAL entry; loc_rvalid=1 with loc_rdata=0xA5 one cycle later.
3. Both requesting from reset, MAX_BURST=4:
   - The host gets 4 accesses, then empty=1 and full=1.
   - Local gets 4 gnts, then the host resumes.
   - No cycle has both owners driving the RAM.
4. Host rden and wren on addr 7 in the same cycle (old value 0x11, write 0x22) -> data 0x11 is returned next cycle; a later read returns 0x22.
5. srst asserted during a LOCAL read grant -> loc_rvalid=0, empty=1, full=1, state=IDLE on the next cycle.
6. With MEM8_ARB_HOST_PRIO_EN defined: local holding the RAM, host opens -> one more gnt, then host ownership; local waits until host_req=0.

Source files
------------

// File: rtl/mem8_arbiter_if.sv
// Bundle of the host (Xillybus mem_8), local requester and RAM-side signals around mem8_arbiter.
// slave = the arbiter's view; master = the surrounding host, local requester and RAM.
interface mem8_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              user_r_mem_8_rden;
  logic              user_r_mem_8_empty;
  logic [DATA_W-1:0] user_r_mem_8_data;
  logic              user_r_mem_8_open;
  logic              user_w_mem_8_wren;
  logic              user_w_mem_8_full;
  logic [DATA_W-1:0] user_w_mem_8_data;
  logic              user_w_mem_8_open;
  logic [ADDR_W-1:0] user_mem_8_addr;

  logic              loc_req;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [DATA_W-1:0] loc_wdata;
  logic              loc_gnt;
  logic              loc_rvalid;
  logic [DATA_W-1:0] loc_rdata;

  logic              ram_rden;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  user_r_mem_8_rden, user_r_mem_8_open, user_w_mem_8_wren,
           user_w_mem_8_data, user_w_mem_8_open, user_mem_8_addr,
           loc_req, loc_we, loc_addr, loc_wdata, ram_rdata,
    output user_r_mem_8_empty, user_r_mem_8_data, user_w_mem_8_full,
           loc_gnt, loc_rvalid, loc_rdata,
           ram_rden, ram_wren, ram_addr, ram_wdata
  );

  modport master (
    output user_r_mem_8_rden, user_r_mem_8_open, user_w_mem_8_wren,
           user_w_mem_8_data, user_w_mem_8_open, user_mem_8_addr,
           loc_req, loc_we, loc_addr, loc_wdata, ram_rdata,
    input  user_r_mem_8_empty, user_r_mem_8_data, user_w_mem_8_full,
           loc_gnt, loc_rvalid, loc_rdata,
           ram_rden, ram_wren, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem8_arbiter.sv
// Round-robin, burst-limited sharing of the mem_8 RAM between Xillybus host and a local requester; RAM strobes are combinational, loc_rvalid lags a read grant by 1 cycle.
// Non-owner is stalled (empty/full high, loc_gnt low); `define MEM8_ARB_HOST_PRIO_EN selects fixed host priority instead.
module mem8_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic          bus_clk,
  input  logic          srst,
  mem8_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_HOST, S_LOCAL} state_t;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic       last_local, last_local_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       host_req;
  logic       host_acc;
  logic       loc_acc;
  logic       burst_done;

  always_comb begin
    host_req       = bus.user_r_mem_8_open | bus.user_w_mem_8_open;
    host_acc       = (state == S_HOST) & (bus.user_r_mem_8_rden | bus.user_w_mem_8_wren);
    loc_acc        = (state == S_LOCAL) & bus.loc_req;
    burst_done     = (cnt == BURST_LAST);
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_local_nxt = last_local;

    case (state)
      S_IDLE: begin
`ifdef MEM8_ARB_HOST_PRIO_EN
        if (host_req)         state_nxt = S_HOST;
        else if (bus.loc_req) state_nxt = S_LOCAL;
`else
        if (host_req && (!bus.loc_req || last_local)) state_nxt = S_HOST;
        else if (bus.loc_req)                         state_nxt = S_LOCAL;
`endif
      end
      S_HOST: begin
        if (!host_req) begin
          state_nxt = bus.loc_req ? S_LOCAL : S_IDLE;
`ifndef MEM8_ARB_HOST_PRIO_EN
        end else if (host_acc && burst_done) begin
          if (bus.loc_req) state_nxt = S_LOCAL;
          else             cnt_nxt   = '0;
`endif
        end else begin
          cnt_nxt = cnt + {7'd0, host_acc};
        end
      end
      S_LOCAL: begin
        if (!bus.loc_req) begin
          state_nxt = host_req ? S_HOST : S_IDLE;
`ifdef MEM8_ARB_HOST_PRIO_EN
        end else if (host_req) begin
          state_nxt = S_HOST;
`else
        end else if (burst_done) begin
          if (host_req) state_nxt = S_HOST;
          else          cnt_nxt   = '0;
`endif
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Every state change restarts the burst; IDLE keeps the previous owner for the tie-break.
    if (state_nxt != state) begin
      cnt_nxt = '0;
      if (state_nxt == S_HOST)       last_local_nxt = 1'b0;
      else if (state_nxt == S_LOCAL) last_local_nxt = 1'b1;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (srst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      last_local     <= 1'b1;
      bus.loc_rvalid <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      last_local     <= last_local_nxt;
      bus.loc_rvalid <= loc_acc & ~bus.loc_we;
    end
  end

  always_comb begin
    bus.user_r_mem_8_empty = (state != S_HOST);
    bus.user_w_mem_8_full  = (state != S_HOST);
    bus.user_r_mem_8_data  = bus.ram_rdata;
    bus.loc_rdata          = bus.ram_rdata;
    bus.loc_gnt            = 1'b0;
    bus.ram_rden           = 1'b0;
    bus.ram_wren           = 1'b0;
    bus.ram_addr           = ADDR_W'(0);
    bus.ram_wdata          = DATA_W'(0);
    case (state)
      S_HOST: begin
        bus.ram_rden  = bus.user_r_mem_8_rden;
        bus.ram_wren  = bus.user_w_mem_8_wren;
        bus.ram_addr  = bus.user_mem_8_addr;
        bus.ram_wdata = bus.user_w_mem_8_data;
      end
      S_LOCAL: begin
        bus.loc_gnt   = bus.loc_req;
        bus.ram_rden  = bus.loc_req & ~bus.loc_we;
        bus.ram_wren  = bus.loc_req & bus.loc_we;
        bus.ram_addr  = bus.loc_addr;
        bus.ram_wdata = bus.loc_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem8_arbiter.sv
// Scoreboard bench for mem8_arbiter (round-robin build, MAX_BURST=4) with a behavioural registered RAM.
module tb_mem8_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int MB = 4;

  logic bus_clk = 1'b0;
  logic srst    = 1'b1;
  always #5 bus_clk = ~bus_clk;

  mem8_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem8_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .bus_clk (bus_clk),
    .srst    (srst),
    .bus     (bus)
  );

  logic [DW-1:0] ram     [0:2**AW-1];
  logic [DW-1:0] ref_mem [0:2**AW-1];

  always @(posedge bus_clk) begin
    if (bus.ram_rden === 1'b1) bus.ram_rdata <= ram[bus.ram_addr];
    if (bus.ram_wren === 1'b1) ram[bus.ram_addr] <= bus.ram_wdata;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0]    exp_hrd[$];
  logic [DW-1:0]    exp_lrd[$];
  byte              exp_own[$];
  bit   trace_on     = 1'b0;
  int   overlap      = 0;
  logic host_rd_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic none_expected(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%0h, expected no output", name, act);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a RAM write, host read data or local read data.
  always @(negedge bus_clk) begin
    byte own;
    if (bus.ram_wren === 1'b1) begin
      if (exp_wr.size() == 0) none_expected("ram_write_unexpected", {bus.ram_addr, bus.ram_wdata});
      else chk("ram_write", {bus.ram_addr, bus.ram_wdata}, exp_wr.pop_front());
    end
    if (host_rd_pend) begin
      if (exp_hrd.size() == 0) none_expected("host_rdata_unexpected", bus.user_r_mem_8_data);
      else chk("host_rdata", bus.user_r_mem_8_data, exp_hrd.pop_front());
    end
    if (bus.loc_rvalid === 1'b1) begin
      if (exp_lrd.size() == 0) none_expected("loc_rvalid_unexpected", bus.loc_rdata);
      else chk("loc_rdata", bus.loc_rdata, exp_lrd.pop_front());
    end
    if (trace_on) begin
      if (bus.user_r_mem_8_empty === 1'b0 && (bus.ram_rden === 1'b1 || bus.ram_wren === 1'b1)) own = "H";
      else if (bus.loc_gnt === 1'b1) own = "L";
      else own = "-";
      if (exp_own.size() == 0) none_expected("owner_unexpected", own);
      else chk("owner", own, exp_own.pop_front());
    end
    if (bus.loc_gnt === 1'b1 && (bus.user_r_mem_8_empty !== 1'b1 || bus.user_w_mem_8_full !== 1'b1))
      overlap++;
    host_rd_pend = (bus.ram_rden === 1'b1) && (bus.user_r_mem_8_empty === 1'b0);
  end

  task automatic step();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic host_acc(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int w = 0;
    while (bus.user_w_mem_8_full !== 1'b0 && w < 30) begin step(); w++; end
    chk("host_wait_full", bus.user_w_mem_8_full, 0);
    bus.user_r_mem_8_rden = rd;
    bus.user_w_mem_8_wren = wr;
    bus.user_mem_8_addr   = a;
    bus.user_w_mem_8_data = d;
    if (rd) exp_hrd.push_back(ref_mem[a]);
    if (wr) begin exp_wr.push_back({a, d}); ref_mem[a] = d; end
    step();
    bus.user_r_mem_8_rden = 1'b0;
    bus.user_w_mem_8_wren = 1'b0;
  endtask

  task automatic loc_acc(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int w = 0;
    bus.loc_req   = 1'b1;
    bus.loc_we    = we;
    bus.loc_addr  = a;
    bus.loc_wdata = d;
    while (bus.loc_gnt !== 1'b1 && w < 30) begin step(); w++; end
    chk("loc_wait_gnt", bus.loc_gnt, 1);
    if (we) begin exp_wr.push_back({a, d}); ref_mem[a] = d; end
    else exp_lrd.push_back(ref_mem[a]);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string own_pat;
    int w;
    for (int i = 0; i < 2**AW; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    bus.ram_rdata         = '0;
    bus.user_r_mem_8_rden = 1'b1;
    bus.user_r_mem_8_open = 1'b0;
    bus.user_w_mem_8_wren = 1'b0;
    bus.user_w_mem_8_data = '0;
    bus.user_w_mem_8_open = 1'b0;
    bus.user_mem_8_addr   = '0;
    bus.loc_req           = 1'b1;
    bus.loc_we            = 1'b0;
    bus.loc_addr          = '0;
    bus.loc_wdata         = '0;

    // Reset: requests asserted must not leak through.
    srst = 1'b1;
    step();
    step();
    chk("reset_outputs",
        {bus.user_r_mem_8_empty, bus.user_w_mem_8_full, bus.loc_gnt,
         bus.loc_rvalid, bus.ram_rden, bus.ram_wren}, 6'b110000);

    // Host write only.
    srst = 1'b0;
    bus.user_r_mem_8_rden = 1'b0;
    bus.loc_req           = 1'b0;
    bus.user_w_mem_8_open = 1'b1;
    chk("full_in_reset_cycle", bus.user_w_mem_8_full, 1);
    step();
    chk("full_after_reset", bus.user_w_mem_8_full, 0);
    host_acc(1'b0, 1'b1, 5'd3, 8'hA5);
    bus.user_w_mem_8_open = 1'b0;
    step();
    chk("stall_after_close", bus.user_w_mem_8_full, 1);

    // Local read of the host's data, then a local write.
    loc_acc(1'b0, 5'd3, 8'h00);
    chk("loc_rvalid_timing", bus.loc_rvalid, 1);
    loc_acc(1'b1, 5'd5, 8'h3C);
    bus.loc_req = 1'b0;
    chk("loc_rvalid_after_write", bus.loc_rvalid, 0);
    step();

    // Simultaneous read and write: read returns the old value.
    bus.user_r_mem_8_open = 1'b1;
    bus.user_w_mem_8_open = 1'b1;
    host_acc(1'b0, 1'b1, 5'd7, 8'h11);
    host_acc(1'b1, 1'b1, 5'd7, 8'h22);
    host_acc(1'b1, 1'b0, 5'd7, 8'h00);
    host_acc(1'b1, 1'b0, 5'd5, 8'h00);
    host_acc(1'b1, 1'b0, 5'd3, 8'h00);
    bus.user_r_mem_8_open = 1'b0;
    bus.user_w_mem_8_open = 1'b0;
    step();

    // Both requesting from reset: host burst of 4, local burst of 4, host again.
    srst = 1'b1;
    step();
    srst = 1'b0;
    bus.user_w_mem_8_open = 1'b1;
    bus.loc_req = 1'b1;
    bus.loc_we  = 1'b0;
    bus.loc_addr = 5'd8;
    own_pat = "-HHHHLLLLHHHH";
    for (int i = 0; i < own_pat.len(); i++) exp_own.push_back(own_pat[i]);
    trace_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 8; k++) host_acc(1'b0, 1'b1, AW'(8 + k), DW'(8'h40 + k));
      end
      begin
        for (int j = 0; j < 4; j++) loc_acc(1'b0, AW'(8 + j), 8'h00);
        bus.loc_req = 1'b0;
      end
    join
    trace_on = 1'b0;
    bus.user_w_mem_8_open = 1'b0;
    step();

    // Reset during a local read grant.
    bus.loc_req  = 1'b1;
    bus.loc_we   = 1'b0;
    bus.loc_addr = 5'd8;
    w = 0;
    while (bus.loc_gnt !== 1'b1 && w < 10) begin step(); w++; end
    chk("loc_gnt_before_reset", bus.loc_gnt, 1);
    srst = 1'b1;
    step();
    chk("reset_midtenure",
        {bus.loc_rvalid, bus.user_r_mem_8_empty, bus.user_w_mem_8_full, bus.loc_gnt}, 4'b0110);
    srst = 1'b0;
    bus.loc_req = 1'b0;
    step();

    // RAM contents survive the reset.
    bus.user_r_mem_8_open = 1'b1;
    host_acc(1'b1, 1'b0, 5'd8, 8'h00);
    host_acc(1'b1, 1'b0, 5'd3, 8'h00);
    bus.user_r_mem_8_open = 1'b0;
    step();
    step();

    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("host_rd_queue_drained", exp_hrd.size(), 0);
    chk("loc_rd_queue_drained", exp_lrd.size(), 0);
    chk("owner_trace_drained", exp_own.size(), 0);
    chk("no_dual_owner", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
